// File: rtl/sobel_stream_3x3_if.sv
// Stream bundle for sobel_stream_3x3: pixel input, runtime controls and edge-pixel output.
// Defining SOBEL_DIR_OUT_EN adds the 2-bit gradient direction output out_dir.
interface sobel_stream_3x3_if #(
    parameter int XW = 9,
    parameter int YW = 8
);
    logic          enable;
    logic          in_valid;
    logic          in_sof;
    logic [11:0]   in_data;
    logic [10:0]   threshold;
    logic          bin_mode;
    logic          out_valid;
    logic [7:0]    out_pix;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic          out_eof;
`ifdef SOBEL_DIR_OUT_EN
    logic [1:0]    out_dir;

    modport master (
        output enable, in_valid, in_sof, in_data, threshold, bin_mode,
        input  out_valid, out_pix, out_x, out_y, out_eof, out_dir
    );
    modport slave (
        input  enable, in_valid, in_sof, in_data, threshold, bin_mode,
        output out_valid, out_pix, out_x, out_y, out_eof, out_dir
    );
`else
    modport master (
        output enable, in_valid, in_sof, in_data, threshold, bin_mode,
        input  out_valid, out_pix, out_x, out_y, out_eof
    );
    modport slave (
        input  enable, in_valid, in_sof, in_data, threshold, bin_mode,
        output out_valid, out_pix, out_x, out_y, out_eof
    );
`endif
endinterface

// File: rtl/sobel_stream_3x3.sv
// Streaming 3x3 Sobel edge detector over RGB444 raster input, two IMG_W x 8 line buffers,
// four-stage pipeline (window, gradients, magnitude, output). Macro SOBEL_DIR_OUT_EN adds out_dir.
module sobel_stream_3x3 #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input  logic               clk,
    input  logic               rst_n,
    sobel_stream_3x3_if.slave  bus
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    typedef enum logic {IDLE, ACTIVE} state_e;

    typedef struct packed {
        logic          valid;
        logic          eof;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } tag_t;

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          accept;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;

    logic [5:0]    rgb_sum;
    logic [11:0]   gray_prod;
    logic [7:0]    gray;
    logic [7:0]    tap_near, tap_far;
    logic [7:0]    lb_near_mem [IMG_W];
    logic [7:0]    lb_far_mem  [IMG_W];

    logic [7:0]         win_q [3][3];
    logic [7:0]         win_d [3][3];
    logic signed [12:0] p [3][3];
    tag_t               tag_s0_q, tag_s0_d, tag_s1_q, tag_s1_d, tag_s2_q, tag_s2_d;
    logic signed [12:0] gx_q, gx_d, gy_q, gy_d;
    logic [12:0]        abs_gx, abs_gy;
    logic [10:0]        mag_q, mag_d;

    logic          out_valid_q, out_valid_d;
    logic [7:0]    out_pix_q, out_pix_d;
    logic [XW-1:0] out_x_q, out_x_d;
    logic [YW-1:0] out_y_q, out_y_d;
    logic          out_eof_q, out_eof_d;
`ifdef SOBEL_DIR_OUT_EN
    logic [1:0]    dir_q, dir_d, out_dir_q, out_dir_d;
`endif

    // Frame tracking: an in_sof pixel is always (0,0), otherwise the counters give its position.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        accept  = bus.enable & bus.in_valid & ((state_q == ACTIVE) | bus.in_sof);
        pix_x   = bus.in_sof ? '0 : x_q;
        pix_y   = bus.in_sof ? '0 : y_q;
        if (accept) begin
            state_d = ACTIVE;
            if (pix_x == X_LAST) begin
                x_d = '0;
                if (pix_y == Y_LAST) begin
                    state_d = IDLE;
                    y_d     = '0;
                end else begin
                    y_d = pix_y + 1'b1;
                end
            end else begin
                x_d = pix_x + 1'b1;
                y_d = pix_y;
            end
        end
    end

    // S0: grayscale, line-buffer taps and window shift; window row 2 is the current line.
    always_comb begin
        rgb_sum   = 6'(bus.in_data[11:8]) + 6'(bus.in_data[7:4]) + 6'(bus.in_data[3:0]);
        gray_prod = 12'(rgb_sum) * 12'd91;
        gray      = 8'(gray_prod >> 4);
        tap_near  = lb_near_mem[pix_x];
        tap_far   = lb_far_mem[pix_x];
        win_d     = win_q;
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = tap_far;
            win_d[1][2] = tap_near;
            win_d[2][2] = gray;
        end
        tag_s0_d.valid = accept & (pix_x >= XW'(2)) & (pix_y >= YW'(2));
        tag_s0_d.eof   = (pix_x == X_LAST) & (pix_y == Y_LAST);
        tag_s0_d.x     = pix_x - 1'b1;
        tag_s0_d.y     = pix_y - 1'b1;
    end

    // NOTE: line-buffer storage is deliberately left out of reset; rows 0..1 of each frame refill it before it is read.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_near_mem[pix_x] <= gray;
            lb_far_mem[pix_x]  <= tap_near;
        end
    end

    // S1 gradients, S2 magnitude (and direction), S3 output formatting.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                p[r][c] = signed'(13'(win_q[r][c]));
            end
        end
        gx_d     = (p[0][2] + (p[1][2] <<< 1) + p[2][2]) - (p[0][0] + (p[1][0] <<< 1) + p[2][0]);
        gy_d     = (p[2][0] + (p[2][1] <<< 1) + p[2][2]) - (p[0][0] + (p[0][1] <<< 1) + p[0][2]);
        tag_s1_d = tag_s0_q;

        abs_gx   = gx_q[12] ? 13'(-gx_q) : 13'(gx_q);
        abs_gy   = gy_q[12] ? 13'(-gy_q) : 13'(gy_q);
        mag_d    = 11'(abs_gx + abs_gy);
        tag_s2_d = tag_s1_q;
`ifdef SOBEL_DIR_OUT_EN
        if ({1'b0, abs_gx} >= {abs_gy, 1'b0}) begin
            dir_d = 2'd0;
        end else if ({1'b0, abs_gy} >= {abs_gx, 1'b0}) begin
            dir_d = 2'd1;
        end else begin
            dir_d = (gx_q[12] == gy_q[12]) ? 2'd2 : 2'd3;
        end
        out_dir_d = out_dir_q;
`endif

        out_valid_d = tag_s2_q.valid;
        out_eof_d   = tag_s2_q.valid & tag_s2_q.eof;
        out_pix_d   = out_pix_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        if (tag_s2_q.valid) begin
            if (bus.bin_mode) begin
                out_pix_d = (mag_q > bus.threshold) ? 8'hFF : 8'h00;
            end else begin
                out_pix_d = mag_q[10:3];
            end
            out_x_d = tag_s2_q.x;
            out_y_d = tag_s2_q.y;
`ifdef SOBEL_DIR_OUT_EN
            out_dir_d = dir_q;
`endif
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            win_q       <= '{default: '0};
            tag_s0_q    <= '0;
            tag_s1_q    <= '0;
            tag_s2_q    <= '0;
            gx_q        <= '0;
            gy_q        <= '0;
            mag_q       <= '0;
            out_valid_q <= 1'b0;
            out_pix_q   <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_eof_q   <= 1'b0;
`ifdef SOBEL_DIR_OUT_EN
            dir_q       <= '0;
            out_dir_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            win_q       <= win_d;
            tag_s0_q    <= tag_s0_d;
            tag_s1_q    <= tag_s1_d;
            tag_s2_q    <= tag_s2_d;
            gx_q        <= gx_d;
            gy_q        <= gy_d;
            mag_q       <= mag_d;
            out_valid_q <= out_valid_d;
            out_pix_q   <= out_pix_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_eof_q   <= out_eof_d;
`ifdef SOBEL_DIR_OUT_EN
            dir_q       <= dir_d;
            out_dir_q   <= out_dir_d;
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_pix   = out_pix_q;
    assign bus.out_x     = out_x_q;
    assign bus.out_y     = out_y_q;
    assign bus.out_eof   = out_eof_q;
`ifdef SOBEL_DIR_OUT_EN
    assign bus.out_dir   = out_dir_q;
`endif
endmodule
